// File: rtl/genius_game_ng.sv
// genius_game_ng: color-sequence memory game; define GENIUS_TIMEOUT_EN to lose after player inactivity
module genius_game_ng #(
    parameter int NUM_COLORS    = 4,
    parameter int MAX_LEN       = 32,
    parameter int FAST_TICKS    = 25_000_000,
    parameter int SLOW_TICKS    = 50_000_000,
    parameter int TIMEOUT_TICKS = 250_000_000,
    localparam int COLOR_W      = $clog2(NUM_COLORS),
    localparam int ADDR_W       = $clog2(MAX_LEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  speed,
    input  logic [1:0]            difficulty,
    input  logic [NUM_COLORS-1:0] btn,
    output logic [NUM_COLORS-1:0] led,
    output logic [ADDR_W-1:0]     score,
    output logic                  busy,
    output logic                  win,
    output logic                  lose
);
    typedef enum logic [2:0] {IDLE, ADD, PLAY_ON, PLAY_OFF, WAIT_IN, WIN, LOSE} state_t;
    localparam logic [COLOR_W:0] NC = (COLOR_W + 1)'(NUM_COLORS);
    state_t st, nxt;
    logic [COLOR_W-1:0] mem [MAX_LEN];
    logic [15:0] lfsr;
    logic start_q, mode_l, speed_l;
    logic [NUM_COLORS-1:0] btn_q, rise;
    logic [ADDR_W-1:0] target, tgt, length, idx;
    logic [31:0] cnt, tgt_raw;
    logic [COLOR_W:0] raw;
    logic [COLOR_W-1:0] rnd, press_color, cur, wr_color;
    logic start_rise, press_ok, phase_end, last, match, idle, wr_en, timeout;
    assign start_rise = start & ~start_q;
    assign rise       = btn & ~btn_q;
    assign press_ok   = $onehot(rise) && btn == rise;
    assign raw        = {1'b0, lfsr[COLOR_W-1:0]};
    assign rnd        = COLOR_W'(raw >= NC ? raw - NC : raw);
    assign cur        = mem[idx[ADDR_W-2:0]];
    assign match      = press_color == cur;
    assign last       = idx == length - 1'b1;
    assign phase_end  = cnt == (speed_l ? 32'(FAST_TICKS - 1) : 32'(SLOW_TICKS - 1));
    assign idle       = st == IDLE || st == WIN || st == LOSE;
    assign wr_en      = st == ADD && (!mode_l || press_ok);
    assign wr_color   = mode_l ? press_color : rnd;
    assign tgt_raw    = difficulty == 2'd0 ? 32'd8 : difficulty == 2'd1 ? 32'd16 :
                        difficulty == 2'd2 ? 32'd32 : 32'(MAX_LEN);
    assign tgt        = ADDR_W'(tgt_raw > 32'(MAX_LEN) ? 32'(MAX_LEN) : tgt_raw);
`ifdef GENIUS_TIMEOUT_EN
    logic [31:0] to_cnt;
    // count cycles spent in WAIT_IN since the last accepted press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else
            to_cnt <= (st == WAIT_IN && !press_ok) ? to_cnt + 32'd1 : '0;
    end
    assign timeout = st == WAIT_IN && to_cnt == 32'(TIMEOUT_TICKS - 1);
`else
    assign timeout = TIMEOUT_TICKS < 0;
`endif
    // encode the single rising button into a color index
    always_comb begin
        press_color = '0;
        for (int i = 0; i < NUM_COLORS; i++)
            if (rise[i]) press_color = COLOR_W'(i);
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= IDLE;
        else
            st <= nxt;
    end
    // next-state logic
    always_comb begin
        nxt = st;
        case (st)
            IDLE, WIN, LOSE: nxt = start_rise ? ADD : st;
            ADD:             nxt = wr_en ? PLAY_ON : ADD;
            PLAY_ON:         nxt = phase_end ? PLAY_OFF : PLAY_ON;
            PLAY_OFF:        nxt = !phase_end ? PLAY_OFF : last ? WAIT_IN : PLAY_ON;
            WAIT_IN:         nxt = press_ok ? (!match ? LOSE : !last ? WAIT_IN : length == target ? WIN : ADD)
                                            : timeout ? LOSE : WAIT_IN;
            default:         nxt = IDLE;
        endcase
    end
    // outputs decoded from the current state
    always_comb begin
        led  = st == PLAY_ON ? {{(NUM_COLORS-1){1'b0}}, 1'b1} << cur :
               st == WAIT_IN ? btn : st == WIN ? '1 : '0;
        busy = !idle;
        win  = st == WIN;
        lose = st == LOSE;
    end
    // edge detectors, LFSR, game settings, counters and score
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            btn_q   <= '0;
            lfsr    <= 16'hACE1;
            mode_l  <= 1'b0;
            speed_l <= 1'b0;
            target  <= '0;
            length  <= '0;
            idx     <= '0;
            score   <= '0;
            cnt     <= '0;
        end else begin
            start_q <= start;
            btn_q   <= btn;
            lfsr    <= (lfsr >> 1) ^ ({16{lfsr[0]}} & 16'hB400);
            cnt     <= (st != nxt || !(st == PLAY_ON || st == PLAY_OFF)) ? '0 : cnt + 32'd1;
            if (idle && start_rise) begin
                mode_l  <= mode;
                speed_l <= speed;
                target  <= tgt;
                length  <= '0;
                idx     <= '0;
                score   <= '0;
            end
            if (wr_en) begin
                length <= length + 1'b1;
                idx    <= '0;
            end
            if (st == PLAY_OFF && phase_end)
                idx <= last ? '0 : idx + 1'b1;
            if (st == WAIT_IN && press_ok && match) begin
                idx <= last ? '0 : idx + 1'b1;
                if (last) score <= score + 1'b1;
            end
        end
    end
    // sequence memory, deliberately without reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[length[ADDR_W-2:0]] <= wr_color;
    end
endmodule
